// File: rtl/fir_decimator.sv
// Decimating averager: one mean sample and one peak-to-peak value per 2**LOG2_DECIM inputs, queued in a 2-entry FIFO.
// Optional build macro FIR_DECIM_ROUND_EN selects round-half-up averaging instead of truncation.
module fir_decimator #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DECIM = 3
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic [DATA_W-1:0] o_p2p,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun
);

  localparam int DECIM = 1 << LOG2_DECIM;
  localparam int ACC_W = DATA_W + LOG2_DECIM;
  localparam int CNT_W = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
`ifdef FIR_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] ROUND_TERM = ACC_W'(DECIM >> 1);
`else
  localparam logic signed [ACC_W-1:0] ROUND_TERM = '0;
`endif

  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] min_q, min_d, max_q, max_d;

  logic signed [DATA_W-1:0] din, lo, hi;
  logic signed [ACC_W-1:0]  sum, rnd;
  logic [DATA_W-1:0]        avg, p2p;
  logic                     first, last, win_done;

  assign din = $signed(i_data);

  // Window datapath: lo/hi/sum already include the current sample.
  always_comb begin
    first    = (cnt_q == '0);
    last     = (cnt_q == CNT_LAST);
    lo       = (first || din < min_q) ? din : min_q;
    hi       = (first || din > max_q) ? din : max_q;
    sum      = acc_q + ACC_W'(din);
    rnd      = sum + ROUND_TERM;
    avg      = DATA_W'(rnd >>> LOG2_DECIM);
    p2p      = DATA_W'(hi - lo);
    win_done = i_en & last;

    cnt_d = cnt_q;
    acc_d = acc_q;
    min_d = min_q;
    max_d = max_q;
    if (i_en) begin
      min_d = lo;
      max_d = hi;
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum;
      end
    end
  end

  // Output handshake: a result transfers on every rising edge where o_valid
  // and i_ready are both 1; o_data/o_p2p hold the head until that happens.
  logic [1:0][DATA_W-1:0] dat_q, dat_d, pp_q, pp_d;
  logic                   rd_q, rd_d, wr_q, wr_d;
  logic [1:0]             count_q, count_d;
  logic                   ovr_q, ovr_d;
  logic                   push, pop, full;

  always_comb begin
    full  = (count_q == 2'd2);
    pop   = (count_q != 2'd0) & i_ready;
    push  = win_done & (!full | pop);

    dat_d = dat_q;
    pp_d  = pp_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (push) begin
      dat_d[wr_q] = avg;
      pp_d[wr_q]  = p2p;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    ovr_d = ovr_q | (win_done & full & !pop);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      dat_q   <= '0;
      pp_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      count_q <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      min_q   <= min_d;
      max_q   <= max_d;
      dat_q   <= dat_d;
      pp_q    <= pp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_valid   = (count_q != 2'd0);
  assign o_data    = o_valid ? dat_q[rd_q] : '0;
  assign o_p2p     = o_valid ? pp_q[rd_q] : '0;
  assign o_overrun = ovr_q;

endmodule
